// File: rtl/tick_gen_if.sv
// Bundles the run/pause button, divisor select and the tick outputs of tick_gen.
// Latency: none, wiring only.
// Backpressure: none; the outputs are free-running pulses and levels.
interface tick_gen_if;
    logic       btn;
    logic [1:0] div_sel;
    logic       tick;
    logic       slow_clk;
    logic       running;

    // The stimulus side drives the button and select and watches the outputs.
    modport master (
        output btn,
        output div_sel,
        input  tick,
        input  slow_clk,
        input  running
    );

    // The tick generator consumes the button and select and drives the outputs.
    modport slave (
        input  btn,
        input  div_sel,
        output tick,
        output slow_clk,
        output running
    );
endinterface

// File: rtl/tick_gen.sv
// Run/pause controlled clock divider: emits a one-cycle tick every DIVsel cycles while running.
// Latency: first tick DIVsel cycles after running rises; a button press toggles on the 3rd edge.
// Backpressure: none; the downstream counter must accept every tick.
module tick_gen #(
    parameter int CNT_W = 27,
    parameter int DIV0  = 100000000,
    parameter int DIV1  = 50000000,
    parameter int DIV2  = 10000000,
    parameter int DIV3  = 4
) (
    input  logic        clk,
    input  logic        rst,
    tick_gen_if.slave   bus
);

    // Reject divisors that are too small or whose terminal count will not fit the counter.
    localparam longint CNT_RANGE = longint'(64'd1 << CNT_W);

    if (DIV0 < 2 || longint'(DIV0) - 1 >= CNT_RANGE) begin : g_bad_div0
        $error("tick_gen: DIV0 out of range for CNT_W");
    end
    if (DIV1 < 2 || longint'(DIV1) - 1 >= CNT_RANGE) begin : g_bad_div1
        $error("tick_gen: DIV1 out of range for CNT_W");
    end
    if (DIV2 < 2 || longint'(DIV2) - 1 >= CNT_RANGE) begin : g_bad_div2
        $error("tick_gen: DIV2 out of range for CNT_W");
    end
    if (DIV3 < 2 || longint'(DIV3) - 1 >= CNT_RANGE) begin : g_bad_div3
        $error("tick_gen: DIV3 out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] TERM0   = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] TERM1   = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] TERM2   = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] TERM3   = CNT_W'(DIV3 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             tick_q,  tick_d;
    logic             slow_q,  slow_d;
    logic [CNT_W-1:0] term;
    logic             btn_rise;

    // Terminal count follows div_sel every cycle so a lowered divisor takes effect at once.
    always_comb begin
        term = TERM0;
        case (bus.div_sel)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            default: term = TERM3;
        endcase
    end

    // Next state: button edge detect, run/pause toggle and the divide counter.
    always_comb begin
        sync1_d  = bus.btn;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        btn_rise = sync2_q & ~sync3_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        slow_d   = slow_q;

        // A press that leaves RUN wins over a terminal count: no tick and cnt holds.
        // Using >= lets a shrunken divisor wrap immediately instead of counting to overflow.
        if (state_q == RUN && !btn_rise) begin
            if (cnt_q >= term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                slow_d = ~slow_q;
            end else begin
                cnt_d  = cnt_q + CNT_ONE;
            end
        end

        if (btn_rise) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
        end
    end

    // All state, synchronous reset overriding every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PAUSE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            slow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            slow_q  <= slow_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.slow_clk = slow_q;
    assign bus.running  = (state_q == RUN);

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed scenarios then random button/select/reset traffic.
// Latency: compares every output one half-cycle after each active edge.
// Backpressure: none.
module tb_tick_gen;

    localparam int CNT_W = 8;
    localparam int D0 = 7;
    localparam int D1 = 5;
    localparam int D2 = 6;
    localparam int D3 = 4;

    logic clk;
    logic rst;

    tick_gen_if bus_if();

    tick_gen #(
        .CNT_W (CNT_W),
        .DIV0  (D0),
        .DIV1  (D1),
        .DIV2  (D2),
        .DIV3  (D3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: run flag, divide count, outputs, and btn samples (newest first).
    bit m_run  = 1'b0;
    int m_cnt  = 0;
    bit m_tick = 1'b0;
    bit m_slow = 1'b0;
    bit hist[$] = '{1'b0, 1'b0, 1'b0};

    // Observation bookkeeping taken from the DUT outputs.
    int cyc_n     = 0;
    int t_run     = -1;
    bit prev_run  = 1'b0;
    bit prev_tick = 1'b0;
    int tick_times[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int div_of(input logic [1:0] ds);
        case (ds)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    // A press toggles at the edge where the button sample from two edges back is 1
    // and the one from three edges back is 0.
    task automatic model_step(input bit b, input logic [1:0] ds, input bit r);
        bit tog;
        int term;
        if (r) begin
            m_run = 0; m_cnt = 0; m_tick = 0; m_slow = 0;
            hist = '{1'b0, 1'b0, 1'b0};
        end else begin
            tog    = hist[1] && !hist[2];
            term   = div_of(ds) - 1;
            m_tick = 0;
            if (m_run && !tog) begin
                if (m_cnt >= term) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    m_slow = !m_slow;
                end else begin
                    m_cnt++;
                end
            end
            if (tog) m_run = !m_run;
            hist.push_front(b);
            void'(hist.pop_back());
        end
    endtask

    task automatic cyc(input bit b, input logic [1:0] ds, input bit r);
        bus_if.btn     = b;
        bus_if.div_sel = ds;
        rst            = r;
        @(posedge clk);
        model_step(b, ds, r);
        @(negedge clk);
        cyc_n++;
        chk("tick",      bus_if.tick,     m_tick);
        chk("slow_clk",  bus_if.slow_clk, m_slow);
        chk("running",   bus_if.running,  m_run);
        chk("cnt",       dut.cnt_q,       m_cnt);
        chk("tick_pair", prev_tick & bus_if.tick, 0);
        if (bus_if.running && !prev_run) t_run = cyc_n;
        if (bus_if.tick) tick_times.push_back(cyc_n);
        prev_tick = bus_if.tick;
        prev_run  = bus_if.running;
    endtask

    initial begin
        int t0;
        int k;
        bit b;
        logic [1:0] ds;

        // Reset held three cycles with the button idle, then released.
        repeat (3) cyc(0, 2'd3, 1);
        repeat (3) cyc(0, 2'd3, 0);
        chk("idle_running", bus_if.running, 0);

        // One long press at div 4: toggle on 3rd edge, ticks at +4, +8, +12.
        tick_times.delete();
        t0 = cyc_n;
        repeat (5) cyc(1, 2'd3, 0);
        repeat (12) cyc(0, 2'd3, 0);
        chk("run_edge", t_run - t0, 3);
        chk("tick_count", tick_times.size(), 3);
        if (tick_times.size() >= 3) begin
            chk("tick1_delay", tick_times[0] - t_run, 4);
            chk("tick2_period", tick_times[1] - tick_times[0], 4);
            chk("tick3_period", tick_times[2] - tick_times[1], 4);
        end

        // Second press pauses, third press resumes from the held count.
        repeat (2) cyc(1, 2'd3, 0);
        repeat (8) cyc(0, 2'd3, 0);
        chk("paused", bus_if.running, 0);
        repeat (2) cyc(1, 2'd3, 0);
        repeat (10) cyc(0, 2'd3, 0);
        chk("resumed", bus_if.running, 1);

        // Count to 5 at div 6, then drop to div 4: wrap on the next edge, then period 4.
        k = 0;
        while (dut.cnt_q != 5 && k < 40) begin cyc(0, 2'd2, 0); k++; end
        chk("reach_cnt5", dut.cnt_q, 5);
        tick_times.delete();
        cyc(0, 2'd3, 0);
        chk("wrap_tick", bus_if.tick, 1);
        chk("wrap_cnt", dut.cnt_q, 0);
        repeat (8) cyc(0, 2'd3, 0);
        chk("wrap_ticks", tick_times.size(), 3);
        if (tick_times.size() >= 2) chk("wrap_period", tick_times[1] - tick_times[0], 4);

        // Reset on the edge that would have produced a tick.
        k = 0;
        while (dut.cnt_q != 3 && k < 20) begin cyc(0, 2'd3, 0); k++; end
        chk("reach_cnt3", dut.cnt_q, 3);
        cyc(0, 2'd3, 1);
        chk("rst_tick", bus_if.tick, 0);
        chk("rst_slow", bus_if.slow_clk, 0);
        chk("rst_running", bus_if.running, 0);
        repeat (8) cyc(0, 2'd3, 0);
        chk("post_rst_running", bus_if.running, 0);

        // Start again, then time a press so its toggle lands on cnt == TERM.
        repeat (2) cyc(1, 2'd3, 0);
        k = 0;
        while (!bus_if.running && k < 10) begin cyc(0, 2'd3, 0); k++; end
        chk("restart", bus_if.running, 1);
        k = 0;
        while (dut.cnt_q != 1 && k < 20) begin cyc(0, 2'd3, 0); k++; end
        chk("reach_cnt1", dut.cnt_q, 1);
        repeat (3) cyc(1, 2'd3, 0);
        chk("coll_running", bus_if.running, 0);
        chk("coll_tick", bus_if.tick, 0);
        chk("coll_cnt", dut.cnt_q, 3);
        repeat (4) cyc(0, 2'd3, 0);
        chk("coll_hold", dut.cnt_q, 3);

        // Random traffic: held button levels, occasional select changes and resets.
        b  = 0;
        ds = 2'd3;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) b = !b;
            if ($urandom_range(19) == 0) ds = 2'($urandom_range(3));
            cyc(b, ds, $urandom_range(99) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 27, giving the divide-counter width in bits.
REQ-002 The block SHALL have parameter DIV0, default 100000000, giving the divisor for div_sel=0 (1 Hz at 100 MHz).
REQ-003 The block SHALL have parameter DIV1, default 50000000, giving the divisor for div_sel=1.
REQ-004 The block SHALL have parameter DIV2, default 10000000, giving the divisor for div_sel=2.
REQ-005 The block SHALL have parameter DIV3, default 4, giving the divisor for div_sel=3 (simulation/fast mode).
REQ-006 Every DIVn SHALL be >= 2 and DIVn-1 SHALL fit in CNT_W bits; a violation is a configuration error.
REQ-007 Port clk: input, 1 bit; the single clock, and all state updates on its rising edge.
REQ-008 Port rst: input, 1 bit; synchronous, active-high reset.
REQ-009 Port btn: input, 1 bit; raw asynchronous run/pause push-button, active high.
REQ-010 Port div_sel: input, 2 bits; divisor select, sampled every cycle.
REQ-011 Port tick: output, 1 bit; registered one-cycle enable pulse to the downstream 4-bit up-counter.
REQ-012 Port slow_clk: output, 1 bit; registered square wave toggling on every tick.
REQ-013 Port running: output, 1 bit; high when the FSM is in RUN.

Function
REQ-014 btn SHALL pass through a two-flop synchronizer, then a third flop; a rise is detected when sync2=1 and the third flop=0.
REQ-015 A detected rise SHALL toggle the FSM between PAUSE and RUN on the next clk edge; that edge is the 3rd rising edge after btn goes high with setup met.
REQ-016 Each detected rise SHALL cause exactly one toggle; holding btn high SHALL cause no further toggles.
REQ-017 The FSM SHALL have two states: PAUSE (running=0) and RUN (running=1).
REQ-018 Let TERM = DIVsel-1, where DIVsel is selected combinationally from the current div_sel.
REQ-019 In RUN with cnt >= TERM: cnt SHALL go to 0, and tick SHALL be 1 in the following cycle.
REQ-020 In RUN with cnt < TERM: cnt SHALL go to cnt+1, and tick SHALL be 0.
REQ-021 In PAUSE, cnt SHALL hold its value and tick SHALL be 0.
REQ-022 Entering RUN with cnt=0 SHALL make the first tick high exactly DIVsel cycles after running rises, with a period of DIVsel cycles after that.
REQ-023 If div_sel is lowered so that cnt > new TERM, the next RUN cycle SHALL wrap cnt to 0 and produce a tick; there SHALL be no overflow and no long wait.
REQ-024 If a toggle to PAUSE coincides with cnt >= TERM, pause SHALL win: no tick, and cnt holds.
REQ-025 If a toggle to RUN occurs, counting SHALL start in the first RUN cycle; cnt SHALL resume from its held value.
REQ-026 slow_clk SHALL invert on the same edge at which tick is registered high, giving a period of 2*DIVsel cycles.
REQ-027 tick SHALL never be high for two consecutive cycles.

Reset
REQ-028 On any clk edge with rst=1: state=PAUSE, cnt=0, tick=0, slow_clk=0, running=0, and all three btn flops=0.
REQ-029 rst SHALL override every other event in the same cycle, including a btn rise and a terminal count.
REQ-030 Reset mid-RUN SHALL suppress any pending tick; after rst falls, the block SHALL stay in PAUSE until a new btn rise.

Verification
REQ-031 Scenario: rst for 3 cycles with btn=0 -> tick=0, slow_clk=0, running=0 throughout and after release.
REQ-032 Scenario: div_sel=3 (DIV3=4); pulse btn for 5 cycles -> running=1 on the 3rd edge, then ticks 4, 8, 12 cycles later; slow_clk toggles at each tick; exactly one toggle.
REQ-033 Scenario: while running with div_sel=3, press btn again -> running=0 and tick stays 0; a third press resumes from the held cnt.
REQ-034 Scenario: bench DIV2=6, div_sel=2, cnt reaches 5; switch to div_sel=3 -> wrap and tick on the next cycle, then period 4.
REQ-035 Scenario: assert rst one cycle before an expected tick -> no tick, all outputs 0, running stays 0 after release.
REQ-036 Scenario: btn rise timed so the toggle edge coincides with cnt=TERM -> running=0, no tick, cnt holds 3.
